// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
// At most one request is outstanding; the address stays stable from request until ack.
interface fetch_stage_if #(
    parameter int PC_W = 32
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the pipelined MIPS core.
// Owns the PC, fetches one word at a time over a req/ack bus, and supports stall and branch flush.
module fetch_stage #(
    parameter int            PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_stage_if.master   imem,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [31:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc_plus4,
    output logic [PC_W-1:0] pc_out
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StStall,
        StDiscard
    } fetchState_e;

    fetchState_e     r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_pending;
    logic [31:0]     r_skid;
    logic [PC_W-1:0] r_skidPc4;
    logic            r_ifIdValid;
    logic [31:0]     r_ifIdInstr;
    logic [PC_W-1:0] r_ifIdPc4;

    fetchState_e     w_stateNext;
    logic [PC_W-1:0] w_pcNext;
    logic [PC_W-1:0] w_pendingNext;
    logic [31:0]     w_skidNext;
    logic [PC_W-1:0] w_skidPc4Next;
    logic            w_ifIdValidNext;
    logic [31:0]     w_ifIdInstrNext;
    logic [PC_W-1:0] w_ifIdPc4Next;
    logic [PC_W-1:0] w_pcPlus4;
    logic            w_ifIdFree;

    assign w_pcPlus4  = r_pc + PC_W'(4);
    assign w_ifIdFree = !r_ifIdValid || !stall_i;

    assign imem.imem_req  = (r_state == StFetch) || (r_state == StDiscard);
    assign imem.imem_addr = r_pc;

    assign if_id_valid    = r_ifIdValid;
    assign if_id_instr    = r_ifIdInstr;
    assign if_id_pc_plus4 = r_ifIdPc4;
    assign pc_out         = r_pc;

    always_comb begin
        w_stateNext     = r_state;
        w_pcNext        = r_pc;
        w_pendingNext   = r_pending;
        w_skidNext      = r_skid;
        w_skidPc4Next   = r_skidPc4;
        w_ifIdValidNext = r_ifIdValid;
        w_ifIdInstrNext = r_ifIdInstr;
        w_ifIdPc4Next   = r_ifIdPc4;

        // Decode consumed the entry; it goes stale unless something new is loaded below.
        if (!stall_i) begin
            w_ifIdValidNext = 1'b0;
        end

        case (r_state)
            StIdle: begin
                w_stateNext = StFetch;
            end
            StFetch: begin
                if (flush_i && imem.imem_ack) begin
                    w_pcNext = redirect_pc;
                end else if (flush_i) begin
                    w_pendingNext = redirect_pc;
                    w_stateNext   = StDiscard;
                end else if (imem.imem_ack && w_ifIdFree) begin
                    w_ifIdValidNext = 1'b1;
                    w_ifIdInstrNext = imem.imem_rdata;
                    w_ifIdPc4Next   = w_pcPlus4;
                    w_pcNext        = w_pcPlus4;
                end else if (imem.imem_ack) begin
                    w_skidNext    = imem.imem_rdata;
                    w_skidPc4Next = w_pcPlus4;
                    w_pcNext      = w_pcPlus4;
                    w_stateNext   = StStall;
                end
            end
            // The skid is full exactly while in this state, so no separate occupancy flag.
            StStall: begin
                if (flush_i) begin
                    w_pcNext    = redirect_pc;
                    w_stateNext = StFetch;
                end else if (!stall_i) begin
                    w_ifIdValidNext = 1'b1;
                    w_ifIdInstrNext = r_skid;
                    w_ifIdPc4Next   = r_skidPc4;
                    w_stateNext     = StFetch;
                end
            end
            StDiscard: begin
                if (imem.imem_ack) begin
                    w_pcNext    = flush_i ? redirect_pc : r_pending;
                    w_stateNext = StFetch;
                end else if (flush_i) begin
                    w_pendingNext = redirect_pc;
                end
            end
            default: begin
                w_stateNext = StIdle;
            end
        endcase

        if (flush_i) begin
            w_ifIdValidNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_pc        <= RESET_PC;
            r_pending   <= '0;
            r_skid      <= '0;
            r_skidPc4   <= '0;
            r_ifIdValid <= 1'b0;
            r_ifIdInstr <= '0;
            r_ifIdPc4   <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_pc        <= w_pcNext;
            r_pending   <= w_pendingNext;
            r_skid      <= w_skidNext;
            r_skidPc4   <= w_skidPc4Next;
            r_ifIdValid <= w_ifIdValidNext;
            r_ifIdInstr <= w_ifIdInstrNext;
            r_ifIdPc4   <= w_ifIdPc4Next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/flush/ack traffic
// compared against a queue-based model of the fetch stream.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall;
    logic        flush;
    logic [31:0] redirectPc;
    logic        ifIdValid;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPc4;
    logic [31:0] pcOut;

    logic        wrapValid;
    logic [31:0] wrapInstr;
    logic [31:0] wrapPc4;
    logic [31:0] wrapPcOut;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    // Address-tagged memory contents so every delivered word identifies its fetch address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    fetch_stage_if #(.PC_W(32)) imemBus();
    fetch_stage_if #(.PC_W(32)) wrapBus();

    assign wrapBus.imem_ack   = wrapBus.imem_req;
    assign wrapBus.imem_rdata = memWord(wrapBus.imem_addr);

    fetch_stage #(.PC_W(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imemBus),
        .stall_i        (stall),
        .flush_i        (flush),
        .redirect_pc    (redirectPc),
        .if_id_valid    (ifIdValid),
        .if_id_instr    (ifIdInstr),
        .if_id_pc_plus4 (ifIdPc4),
        .pc_out         (pcOut)
    );

    fetch_stage #(.PC_W(32), .RESET_PC(WRAP_PC)) dutWrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (wrapBus),
        .stall_i        (1'b0),
        .flush_i        (1'b0),
        .redirect_pc    (32'h0),
        .if_id_valid    (wrapValid),
        .if_id_instr    (wrapInstr),
        .if_id_pc_plus4 (wrapPc4),
        .pc_out         (wrapPcOut)
    );

    // Reference model: the words waiting for decode (IF/ID first, then the skid) and the next fetch address.
    logic [31:0] qInstr[$];
    logic [31:0] qPc4[$];
    logic [31:0] mAddr;
    logic [31:0] mPending;
    bit          mIdle;
    bit          mDiscard;

    function automatic bit expReq();
        return !mIdle && (qInstr.size() < 2);
    endfunction

    task automatic modelReset();
        qInstr.delete();
        qPc4.delete();
        mAddr    = RESET_PC;
        mPending = '0;
        mIdle    = 1'b1;
        mDiscard = 1'b0;
    endtask

    // One clock edge of the model, given the inputs applied during that cycle.
    task automatic modelStep(input logic st, input logic fl, input logic [31:0] rd, input logic ack);
        bit busy;
        busy = expReq();
        if (mIdle) begin
            mIdle = 1'b0;
        end else if (fl) begin
            qInstr.delete();
            qPc4.delete();
            if (busy && !ack) begin
                mDiscard = 1'b1;
                mPending = rd;
            end else begin
                mAddr    = rd;
                mDiscard = 1'b0;
            end
        end else begin
            if (qInstr.size() > 0 && !st) begin
                void'(qInstr.pop_front());
                void'(qPc4.pop_front());
            end
            if (busy && ack) begin
                if (mDiscard) begin
                    mAddr    = mPending;
                    mDiscard = 1'b0;
                end else begin
                    qInstr.push_back(memWord(mAddr));
                    qPc4.push_back(mAddr + 32'd4);
                    mAddr = mAddr + 32'd4;
                end
            end
        end
    endtask

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic compareAll();
        checkOutput("req", 32'(imemBus.imem_req), 32'(expReq()));
        if (expReq()) begin
            checkOutput("addr", imemBus.imem_addr, mAddr);
        end
        checkOutput("valid", 32'(ifIdValid), 32'(qInstr.size() > 0));
        if (qInstr.size() > 0) begin
            checkOutput("instr", ifIdInstr, qInstr[0]);
            checkOutput("pc4", ifIdPc4, qPc4[0]);
        end
        checkOutput("pcOut", pcOut, mAddr);
    endtask

    // Called at a falling edge: check the current outputs, drive one cycle of inputs, advance the model.
    // ackMode: 0 = no ack, 1 = ack whenever a request is expected, 2 = ack regardless (stray).
    task automatic applyStimulus(input logic st, input logic fl, input logic [31:0] rd, input int ackMode);
        logic ack;
        compareAll();
        ack = (ackMode == 2) || (ackMode == 1 && expReq());
        stall      = st;
        flush      = fl;
        redirectPc = rd;
        imemBus.imem_ack   = ack;
        imemBus.imem_rdata = ack ? memWord(imemBus.imem_addr) : $urandom;
        modelStep(st, fl, rd, ack);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        stall = 1'b0;
        flush = 1'b0;
        redirectPc = '0;
        imemBus.imem_ack = 1'b0;
        imemBus.imem_rdata = '0;
        @(negedge clk);
        checkOutput("rstReq", 32'(imemBus.imem_req), 32'd0);
        checkOutput("rstValid", 32'(ifIdValid), 32'd0);
        checkOutput("rstInstr", ifIdInstr, 32'd0);
        checkOutput("rstPc4", ifIdPc4, 32'd0);
        checkOutput("rstPc", pcOut, RESET_PC);
        rst_n = 1'b1;
    endtask

    // Reset pulsed while a request is outstanding, followed by a stray ack while idle.
    task automatic midRequestReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 0);
        applyStimulus(1'b0, 1'b0, 32'h0, 0);
        checkOutput("midReqPending", 32'(imemBus.imem_req), 32'd1);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midRstReq", 32'(imemBus.imem_req), 32'd0);
        checkOutput("midRstValid", 32'(ifIdValid), 32'd0);
        checkOutput("midRstPc4", ifIdPc4, 32'd0);
        checkOutput("midRstPc", pcOut, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 2);
        checkOutput("postRstReq", 32'(imemBus.imem_req), 32'd1);
        checkOutput("postRstAddr", imemBus.imem_addr, RESET_PC);
        checkOutput("postRstValid", 32'(ifIdValid), 32'd0);
    endtask

    // The wrap instance acks every request; its PC+4 must roll over to zero.
    initial begin
        @(posedge rst_n);
        #1;
        checkOutput("wrapIdleReq", 32'(wrapBus.imem_req), 32'd0);
        checkOutput("wrapResetPc", wrapPcOut, WRAP_PC);
        @(negedge clk);
        checkOutput("wrapReq", 32'(wrapBus.imem_req), 32'd1);
        checkOutput("wrapAddr", wrapBus.imem_addr, WRAP_PC);
        @(negedge clk);
        checkOutput("wrapValid", 32'(wrapValid), 32'd1);
        checkOutput("wrapPc4", wrapPc4, 32'd0);
        checkOutput("wrapInstr", wrapInstr, memWord(WRAP_PC));
        checkOutput("wrapNextAddr", wrapBus.imem_addr, 32'd0);
    end

    initial begin
        logic [31:0] rd;
        int          ackMode;

        // Back-to-back fetches with an always-acking memory.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("firstAddr", imemBus.imem_addr, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1);
            checkOutput("seqPc4", ifIdPc4, 32'(4 * i));
            checkOutput("seqValid", 32'(ifIdValid), 32'd1);
            checkOutput("seqAddr", imemBus.imem_addr, 32'(4 * i));
        end

        // Stall with IF/ID holding word@0 while word@4 arrives into the skid.
        doReset();
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        applyStimulus(1'b1, 1'b0, 32'h0, 1);
        checkOutput("stallReq", 32'(imemBus.imem_req), 32'd0);
        checkOutput("stallPc4", ifIdPc4, 32'd4);
        checkOutput("stallInstr", ifIdInstr, memWord(32'h0));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 0);
        end
        checkOutput("stallHoldPc4", ifIdPc4, 32'd4);
        applyStimulus(1'b0, 1'b0, 32'h0, 0);
        checkOutput("releasePc4", ifIdPc4, 32'd8);
        checkOutput("releaseInstr", ifIdInstr, memWord(32'h4));
        checkOutput("releaseAddr", imemBus.imem_addr, 32'd8);

        // Flush while the addr-8 request waits; its data must be discarded.
        applyStimulus(1'b0, 1'b1, 32'h40, 0);
        checkOutput("flushValid", 32'(ifIdValid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("discardAddr", imemBus.imem_addr, 32'd8);
            applyStimulus(1'b0, 1'b0, 32'h0, 0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("redirAddr", imemBus.imem_addr, 32'h40);
        checkOutput("droppedValid", 32'(ifIdValid), 32'd0);

        // Flush coinciding with ack and stall.
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("at40Pc4", ifIdPc4, 32'h44);
        applyStimulus(1'b1, 1'b1, 32'h100, 1);
        checkOutput("ackFlushValid", 32'(ifIdValid), 32'd0);
        checkOutput("ackFlushAddr", imemBus.imem_addr, 32'h100);

        // Randomized traffic, including a reset in the middle of a request.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                midRequestReset();
            end
            rd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 255)) << 2);
            if (expReq()) begin
                ackMode = ($urandom_range(0, 1) == 1) ? 1 : 0;
            end else begin
                ackMode = ($urandom_range(0, 9) == 0) ? 2 : 0;
            end
            applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, rd, ackMode);
        end
        compareAll();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
